n64_pi_host: RTL



---
 rtl/n64_pi_pkg.sv | 18 +
 rtl/n64_pi_host.sv | 137 +++++++++++++
 2 files changed

// File: rtl/n64_pi_pkg.sv
// n64_pi_pkg: PI bus mode encodings and host FSM states shared by host and target.
package n64_pi_pkg;
  typedef enum logic [1:0] {
    MODE_VALID = 2'b00,
    MODE_LOW   = 2'b01,
    MODE_IDLE  = 2'b10,
    MODE_HIGH  = 2'b11
  } e_pi_mode;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_SETTLE,
    S_STROBE,
    S_GAP,
    S_END
  } e_host_state;
endpackage

// File: rtl/n64_pi_host.sv
// n64_pi_host: PI bus initiator turning address/length commands into ALE phases and strobe bursts.
import n64_pi_pkg::*;
module n64_pi_host #(
  parameter int T_ADDR   = 4,
  parameter int T_SETTLE = 4,
  parameter int T_STROBE = 8,
  parameter int T_GAP    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_address,
  input  logic [7:0]  cmd_length,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [15:0] wdata,
  output logic        rdata_valid,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        pi_aleh,
  output logic        pi_alel,
  output logic        pi_read,
  output logic        pi_write,
  output logic        pi_ad_oe,
  output logic [15:0] pi_ad_out,
  input  logic [15:0] pi_ad_in
);
  e_host_state state, state_n;
  e_pi_mode    mode_n;
  logic [7:0]  cnt, cnt_n;
  logic [31:0] adr, adr_n;
  logic [8:0]  rem, rem_n;
  logic        wr, wr_n, expired;
  logic        read_n, write_n, oe_n, wready_n, rvalid_n;
  logic [15:0] ad_out_n, rdata_n;

  function automatic logic [7:0] phase_len(input e_host_state s);
    return (s == S_ADDR_H || s == S_ADDR_L) ? 8'(T_ADDR - 1) :
           (s == S_SETTLE) ? 8'(T_SETTLE - 1) :
           (s == S_STROBE) ? 8'(T_STROBE - 1) :
           (s == S_GAP)    ? 8'(T_GAP - 1) : 8'd0;
  endfunction

  assign expired = cnt == 8'd0;

  // Pins are registered from the next-state decode so they line up with the state register.
  always_comb begin
    state_n  = state;
    adr_n    = adr;
    wr_n     = wr;
    rem_n    = rem;
    rdata_n  = rdata;
    ad_out_n = pi_ad_out;
    wready_n = 1'b0;
    rvalid_n = 1'b0;
    case (state)
      S_IDLE:
        if (cmd_valid && cmd_ready) begin
          state_n = S_ADDR_H;
          adr_n   = cmd_address & ~32'd1;
          wr_n    = cmd_write;
          rem_n   = cmd_length == 8'd0 ? 9'd256 : {1'b0, cmd_length};
        end
      S_ADDR_H: state_n = expired ? S_ADDR_L : state;
      S_ADDR_L: state_n = expired ? S_SETTLE : state;
      S_SETTLE, S_GAP:
        if (expired)
          state_n = (state == S_GAP && rem == 9'd0) ? S_END :
                    (!wr || wdata_valid) ? S_STROBE : state;
      S_STROBE:
        if (expired) begin
          state_n = S_GAP;
          rem_n   = rem - 9'd1;
        end
      S_END:    state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    cnt_n = state_n != state ? phase_len(state_n) : expired ? 8'd0 : cnt - 8'd1;
    if (state_n == S_STROBE && state != S_STROBE && wr) begin
      wready_n = 1'b1;
      ad_out_n = wdata;
    end
    if (state == S_STROBE && state_n == S_GAP && !wr) begin
      rvalid_n = 1'b1;
      rdata_n  = pi_ad_in;
    end
    ad_out_n = state_n == S_ADDR_H ? adr_n[31:16] : state_n == S_ADDR_L ? adr_n[15:0] : ad_out_n;
    mode_n   = state_n == S_ADDR_H ? MODE_HIGH :
               state_n == S_ADDR_L ? MODE_LOW :
               (state_n == S_IDLE || state_n == S_END) ? MODE_IDLE : MODE_VALID;
    oe_n     = state_n == S_ADDR_H || state_n == S_ADDR_L ||
               (wr_n && (state_n == S_STROBE || state_n == S_GAP));
    read_n   = !(state_n == S_STROBE && !wr_n);
    write_n  = !(state_n == S_STROBE && wr_n);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      cnt                <= 8'd0;
      adr                <= 32'd0;
      wr                 <= 1'b0;
      rem                <= 9'd0;
      {pi_aleh, pi_alel} <= MODE_IDLE;
      pi_read            <= 1'b1;
      pi_write           <= 1'b1;
      pi_ad_oe           <= 1'b0;
      pi_ad_out          <= 16'd0;
      cmd_ready          <= 1'b0;
      wdata_ready        <= 1'b0;
      rdata_valid        <= 1'b0;
      rdata              <= 16'd0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      state              <= state_n;
      cnt                <= cnt_n;
      adr                <= adr_n;
      wr                 <= wr_n;
      rem                <= rem_n;
      {pi_aleh, pi_alel} <= mode_n;
      pi_read            <= read_n;
      pi_write           <= write_n;
      pi_ad_oe           <= oe_n;
      pi_ad_out          <= ad_out_n;
      cmd_ready          <= state_n == S_IDLE;
      wdata_ready        <= wready_n;
      rdata_valid        <= rvalid_n;
      rdata              <= rdata_n;
      busy               <= state_n != S_IDLE;
      done               <= state_n == S_END;
    end
  end
endmodule
